// File: rtl/controlador_jogadas.sv
// Round sequencer for the chess-square training game.
// Requests a square from the move generator, validates it (on the board and
// different from the previous target), presents it as the target, waits for
// the player's answer with a timeout and keeps score over N_RODADAS rounds.
// All outputs come straight from registers; the state-dependent ones are
// loaded from the next-state value so they line up with the state itself.
module controlador_jogadas #(
  parameter int N_RODADAS      = 8,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int MAX_TENTATIVAS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] colunaGerada,
  input  logic [3:0] linhaGerada,
  input  logic       jogadaValida,
  input  logic [3:0] colunaJogador,
  input  logic [3:0] linhaJogador,
  output logic       novaJogada,
  output logic [3:0] colunaAlvo,
  output logic [3:0] linhaAlvo,
  output logic       alvoValido,
  output logic       acertou,
  output logic       errou,
  output logic       esgotou,
  output logic [3:0] pontos,
  output logic [3:0] rodada,
  output logic       fim,
  output logic [2:0] db_estado
);

  localparam int TW  = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int TEW = $clog2(MAX_TENTATIVAS + 2);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [TEW-1:0] TENT_MAX  = TEW'(MAX_TENTATIVAS);
  localparam logic [3:0]     ULTIMA    = 4'(N_RODADAS);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    PEDE      = 3'd1,
    CAPTURA   = 3'd2,
    AGUARDA   = 3'd3,
    RESULTADO = 3'd4,
    FIM       = 3'd5
  } estado_t;

  estado_t state_r, next_s;

  logic [3:0]     col_alvo_r, lin_alvo_r, col_alvo_s, lin_alvo_s;
  logic [3:0]     prev_col_r, prev_lin_r, prev_col_s, prev_lin_s;
  logic [3:0]     pontos_r, rodada_r, pontos_s, rodada_s;
  logic [TEW-1:0] tent_r, tent_s;
  logic [TW-1:0]  timer_r, timer_s;
  logic           nova_r, valido_r, acertou_r, errou_r, esgotou_r, fim_r;
  logic           nova_s, valido_s, acertou_s, errou_s, esgotou_s, fim_s;
  logic           gerada_ok_s, acerto_s;

  // True when a coordinate lies on the 8x8 board (1..8).
  function automatic logic no_tabuleiro(input logic [3:0] v);
    return (v >= 4'd1) && (v <= 4'd8);
  endfunction

  // Next-state, datapath and output decisions for every state.
  always_comb begin
    next_s      = state_r;
    col_alvo_s  = col_alvo_r;
    lin_alvo_s  = lin_alvo_r;
    prev_col_s  = prev_col_r;
    prev_lin_s  = prev_lin_r;
    pontos_s    = pontos_r;
    rodada_s    = rodada_r;
    tent_s      = tent_r;
    timer_s     = timer_r;
    acertou_s   = 1'b0;
    errou_s     = 1'b0;
    esgotou_s   = 1'b0;
    gerada_ok_s = no_tabuleiro(colunaGerada) && no_tabuleiro(linhaGerada) &&
                  !((colunaGerada == prev_col_r) && (linhaGerada == prev_lin_r));
    acerto_s    = (colunaJogador == col_alvo_r) && (linhaJogador == lin_alvo_r);
    case (state_r)
      INICIAL: begin
        if (iniciar) begin
          pontos_s = 4'd0;
          rodada_s = 4'd0;
          tent_s   = '0;
          next_s   = PEDE;
        end else begin
          next_s = INICIAL;
        end
      end
      PEDE: begin
        next_s = CAPTURA;
      end
      CAPTURA: begin
        if (gerada_ok_s) begin
          col_alvo_s = colunaGerada;
          lin_alvo_s = linhaGerada;
          prev_col_s = colunaGerada;
          prev_lin_s = linhaGerada;
          tent_s     = '0;
          timer_s    = '0;
          next_s     = AGUARDA;
        end else if (tent_r < TENT_MAX) begin
          tent_s = tent_r + 1'b1;
          next_s = PEDE;
        end else begin
          // Column moves off the previous one, so the square always changes.
          col_alvo_s = (prev_col_r % 4'd8) + 4'd1;
          lin_alvo_s = no_tabuleiro(linhaGerada) ? linhaGerada : 4'd1;
          prev_col_s = (prev_col_r % 4'd8) + 4'd1;
          prev_lin_s = no_tabuleiro(linhaGerada) ? linhaGerada : 4'd1;
          tent_s     = '0;
          timer_s    = '0;
          next_s     = AGUARDA;
        end
      end
      AGUARDA: begin
        if (jogadaValida) begin
          acertou_s = acerto_s;
          errou_s   = !acerto_s;
          rodada_s  = rodada_r + 4'd1;
          pontos_s  = acerto_s ? (pontos_r + 4'd1) : pontos_r;
          next_s    = RESULTADO;
        end else if (timer_r == TIMER_MAX) begin
          esgotou_s = 1'b1;
          rodada_s  = rodada_r + 4'd1;
          next_s    = RESULTADO;
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      RESULTADO: begin
        if (rodada_r == ULTIMA) begin
          next_s = FIM;
        end else begin
          next_s = PEDE;
        end
      end
      FIM: begin
        if (iniciar) begin
          pontos_s = 4'd0;
          rodada_s = 4'd0;
          tent_s   = '0;
          next_s   = PEDE;
        end else begin
          next_s = FIM;
        end
      end
      default: begin
        next_s = INICIAL;
      end
    endcase
    nova_s   = (next_s == PEDE);
    valido_s = (next_s == AGUARDA);
    fim_s    = (next_s == FIM);
  end

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= INICIAL;
      col_alvo_r <= 4'd0;
      lin_alvo_r <= 4'd0;
      prev_col_r <= 4'd0;
      prev_lin_r <= 4'd0;
      pontos_r   <= 4'd0;
      rodada_r   <= 4'd0;
      tent_r     <= '0;
      timer_r    <= '0;
      nova_r     <= 1'b0;
      valido_r   <= 1'b0;
      acertou_r  <= 1'b0;
      errou_r    <= 1'b0;
      esgotou_r  <= 1'b0;
      fim_r      <= 1'b0;
    end else begin
      state_r    <= next_s;
      col_alvo_r <= col_alvo_s;
      lin_alvo_r <= lin_alvo_s;
      prev_col_r <= prev_col_s;
      prev_lin_r <= prev_lin_s;
      pontos_r   <= pontos_s;
      rodada_r   <= rodada_s;
      tent_r     <= tent_s;
      timer_r    <= timer_s;
      nova_r     <= nova_s;
      valido_r   <= valido_s;
      acertou_r  <= acertou_s;
      errou_r    <= errou_s;
      esgotou_r  <= esgotou_s;
      fim_r      <= fim_s;
    end
  end

  assign novaJogada = nova_r;
  assign colunaAlvo = col_alvo_r;
  assign linhaAlvo  = lin_alvo_r;
  assign alvoValido = valido_r;
  assign acertou    = acertou_r;
  assign errou      = errou_r;
  assign esgotou    = esgotou_r;
  assign pontos     = pontos_r;
  assign rodada     = rodada_r;
  assign fim        = fim_r;
  assign db_estado  = state_r;

endmodule
